// File: rtl/counter8_pkg.sv
// Shared types and constants for the up/down counter slice.
// The saturating build is selected with the COUNTER8_SATURATE_EN macro
// (see counter8_updown.sv). This package is the same in both builds.
package counter8_pkg;

  // Default counter width, and the range of widths the design supports.
  localparam int WIDTH_DEFAULT = 8;
  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 16;

  // Count direction, as encoded on the up input.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Events raised by one counter step. wrap drives the registered pulse.
  // ovf_set and unf_set feed the sticky flag registers.
  typedef struct packed {
    logic wrap;
    logic ovf_set;
    logic unf_set;
  } step_evt_t;

endpackage

// File: rtl/counter8_flag.sv
// Sticky event flag with an async active-low reset.
// A set request on the same edge as a clear request wins, so an event
// that arrives while software clears the flag is never lost.
module counter8_flag (
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
);

  logic flag_q;
  logic flag_d;

  // Next state: set beats clear; otherwise hold.
  always_comb begin
    flag_d = flag_q;
    if (set_i) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end
  end

  // Flag register; cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/counter8_updown.sv
// Parameterised up/down counter with a registered wrap pulse and sticky
// overflow/underflow flags. Its count MSB feeds the external overflow
// detector.
// Build option: define COUNTER8_SATURATE_EN to make the counter saturate at
// all-ones/zero instead of wrapping. In that build the wrap pulse and the
// flags still report each attempted crossing.
module counter8_updown
  import counter8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             count_msb,
  output logic             wrap_pulse,
  output logic             ovf_flag,
  output logic             unf_flag
);

  // Boundary constants for this width. Wrap detection compares the current
  // count against these before stepping, so no carry bit is kept in state.
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // These are the values the counter takes when a step tries to cross a
  // boundary. The wrapping build rolls over to the opposite end. The
  // saturating build stays at the end it is already on.
`ifdef COUNTER8_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_CROSS_VAL   = CNT_MAX;
  localparam logic [WIDTH-1:0] DOWN_CROSS_VAL = CNT_MIN;
`else
  localparam logic [WIDTH-1:0] UP_CROSS_VAL   = CNT_MIN;
  localparam logic [WIDTH-1:0] DOWN_CROSS_VAL = CNT_MAX;
`endif

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  step_evt_t        evt;
  dir_e             dir;

  assign dir = dir_e'(up);

  // Step logic. Priority is load, then enabled step, then hold. A load
  // never raises events, even if en is also high on that edge.
  always_comb begin
    count_d = count_q;
    evt     = '0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (count_q == CNT_MAX) begin
          count_d     = UP_CROSS_VAL;
          evt.wrap    = 1'b1;
          evt.ovf_set = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else begin
        if (count_q == CNT_MIN) begin
          count_d     = DOWN_CROSS_VAL;
          evt.wrap    = 1'b1;
          evt.unf_set = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
    end
  end

  assign wrap_d = evt.wrap;

  // Count and wrap-pulse registers. They update together, so the pulse
  // lines up with the first cycle of the post-wrap count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= CNT_MIN;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  counter8_flag u_ovf_flag (
    .clk    (clk),
    .reset  (reset),
    .set_i  (evt.ovf_set),
    .clr_i  (clr_flags),
    .flag_o (ovf_flag)
  );

  counter8_flag u_unf_flag (
    .clk    (clk),
    .reset  (reset),
    .set_i  (evt.unf_set),
    .clr_i  (clr_flags),
    .flag_o (unf_flag)
  );

  assign count      = count_q;
  assign count_msb  = count_q[WIDTH-1];
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_counter8_updown.sv
// Directed bench for counter8_updown at WIDTH=8.
// Each observation is packed as {count, count_msb, wrap_pulse, ovf, unf}.
module tb_counter8_updown;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic       clr_flags;
  logic [7:0] count;
  logic       count_msb;
  logic       wrap_pulse;
  logic       ovf_flag;
  logic       unf_flag;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] obs;
  assign obs = {count, count_msb, wrap_pulse, ovf_flag, unf_flag};

  counter8_updown #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_val   (load_val),
    .clr_flags  (clr_flags),
    .count      (count),
    .count_msb  (count_msb),
    .wrap_pulse (wrap_pulse),
    .ovf_flag   (ovf_flag),
    .unf_flag   (unf_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pk(input logic [7:0] c, input logic w,
                                     input logic o, input logic u);
    return {c, c[7], w, o, u};
  endfunction

  task automatic drive(input logic l, input logic [7:0] lv, input logic e,
                       input logic u, input logic c);
    load = l; load_val = lv; en = e; up = u; clr_flags = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      en = i[0] ? 1'b0 : 1'b1;
      tick();
      n_cmp++;
      if (obs !== pk(8'h00, 1'b0, 1'b0, 1'b0)) begin
        n_bad++;
        $display("FAIL reset_hold c%0d: got %h want %h", i, obs, pk(8'h00, 1'b0, 1'b0, 1'b0));
      end
    end
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (obs !== pk(8'h01, 1'b0, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL reset_release: got %h want %h", obs, pk(8'h01, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_up_wrap;
    logic [11:0] e[4];
    e[0] = pk(8'hFE, 1'b0, 1'b0, 1'b0);
    e[1] = pk(8'hFF, 1'b0, 1'b0, 1'b0);
    e[2] = pk(8'h00, 1'b1, 1'b1, 1'b0);
    e[3] = pk(8'h01, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
      else        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL up_wrap c%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_down_wrap;
    logic [11:0] e[4];
    e[0] = pk(8'h01, 1'b0, 1'b1, 1'b0);
    e[1] = pk(8'h00, 1'b0, 1'b1, 1'b0);
    e[2] = pk(8'hFF, 1'b1, 1'b1, 1'b1);
    e[3] = pk(8'hFE, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      else        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL down_wrap c%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  // Clear the flags, park at FF, then load and step up on the same edge.
  task automatic test_priority;
    logic [11:0] e[3];
    e[0] = pk(8'hFE, 1'b0, 1'b0, 1'b0);
    e[1] = pk(8'hFF, 1'b0, 1'b0, 1'b0);
    e[2] = pk(8'h10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        1:       drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        default: drive(1'b1, 8'h10, 1'b1, 1'b1, 1'b0);
      endcase
      tick();
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL priority c%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_flag_clear;
    logic [11:0] e[3];
    e[0] = pk(8'hFF, 1'b0, 1'b0, 1'b0);
    e[1] = pk(8'h00, 1'b1, 1'b1, 1'b0);
    e[2] = pk(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        1:       drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        default: drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      endcase
      tick();
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL flag_clear c%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  // Step up across the boundary, then straight back down. The two wraps
  // produce consecutive pulses, and a later wrap leaves the sticky flags set.
  task automatic test_back_to_back;
    logic [11:0] e[6];
    e[0] = pk(8'hFF, 1'b0, 1'b0, 1'b0);
    e[1] = pk(8'h00, 1'b1, 1'b1, 1'b0);
    e[2] = pk(8'hFF, 1'b1, 1'b1, 1'b1);
    e[3] = pk(8'hFF, 1'b0, 1'b1, 1'b1);
    e[4] = pk(8'h00, 1'b1, 1'b1, 1'b1);
    e[5] = pk(8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        1:       drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        2:       drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        4:       drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        default: drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      endcase
      tick();
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL back_to_back c%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  // Assert reset between edges. The outputs must clear before the next edge.
  task automatic test_async_reset;
    drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (obs !== pk(8'h55, 1'b0, ovf_flag, unf_flag) || count !== 8'h55) begin
      n_bad++;
      $display("FAIL async_pre: got count %h want %h", count, 8'h55);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== pk(8'h00, 1'b0, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL async_assert: got %h want %h", obs, pk(8'h00, 1'b0, 1'b0, 1'b0));
    end
    tick();
    n_cmp++;
    if (obs !== pk(8'h00, 1'b0, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL async_hold: got %h want %h", obs, pk(8'h00, 1'b0, 1'b0, 1'b0));
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (obs !== pk(8'h01, 1'b0, 1'b0, 1'b0)) begin
      n_bad++;
      $display("FAIL async_release: got %h want %h", obs, pk(8'h01, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_saturate;
    logic [11:0] e[5];
    e[0] = pk(8'hFF, 1'b0, 1'b0, 1'b0);
    e[1] = pk(8'hFF, 1'b1, 1'b1, 1'b0);
    e[2] = pk(8'hFF, 1'b1, 1'b1, 1'b0);
    e[3] = pk(8'h00, 1'b0, 1'b1, 1'b0);
    e[4] = pk(8'h00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        1, 2:    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        3:       drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        default: drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      endcase
      tick();
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL saturate c%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef COUNTER8_SATURATE_EN
    test_saturate();
`else
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_flag_clear();
    test_back_to_back();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
